// File: rtl/store_split_seq.sv
// store_split_seq: expands sb (and sh when STORE_SPLIT_HALF_EN is defined) into a
// pre-load lw x0 followed by the original store; other instructions pass through. Rev 1.0
`default_nettype none

module store_split_seq #(
  parameter int WIDTH_INST = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH_INST-1:0] inst_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH_INST-1:0] out_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_pre
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] PRE  = 2'd2;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic [1:0]            state;
  logic [WIDTH_INST-1:0] pend;
  logic                  is_split;
  logic [WIDTH_INST-1:0] pre_inst;
  logic                  accept;
  logic                  transfer;

  always_comb begin
    is_split = 1'b0;
    if (inst_in[6:0] == OP_STORE) begin
`ifdef STORE_SPLIT_HALF_EN
      is_split = (inst_in[14:12] == 3'b000) || (inst_in[14:12] == 3'b001);
`else
      is_split = (inst_in[14:12] == 3'b000);
`endif
    end
  end

  // Store immediate and base register reused so the load touches the same word.
  assign pre_inst = {inst_in[31:25], inst_in[11:7], inst_in[19:15],
                     3'b010, 5'b00000, OP_LOAD};

  assign out_valid = (state != IDLE);
  assign in_ready  = !flush && (state != PRE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_inst <= '0;
      out_pre  <= 1'b0;
      pend     <= '0;
    end else if (flush) begin
      state   <= IDLE;
      out_pre <= 1'b0;
      pend    <= '0;
    end else begin
      case (state)
        PRE: begin
          if (transfer) begin
            state    <= PASS;
            out_inst <= pend;
            out_pre  <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (is_split) begin
              state    <= PRE;
              out_inst <= pre_inst;
              out_pre  <= 1'b1;
              pend     <= inst_in;
            end else begin
              state    <= PASS;
              out_inst <= inst_in;
              out_pre  <= 1'b0;
            end
          end else if (transfer) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_split_seq.sv
// tb_store_split_seq: directed bench with an expected-output queue for store_split_seq.
`default_nettype none

module tb_store_split_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_inst;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_pre;

  store_split_seq #(.WIDTH_INST(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst_in  (inst_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_inst (out_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pre  (out_pre)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] SB_INST  = 32'h00510223;
  localparam logic [31:0] SB_PRE   = 32'h00412003;
  localparam logic [31:0] SH_INST  = 32'h00511223;
  localparam logic [31:0] ADD_INST = 32'h003100B3;
  localparam logic [31:0] SW_INST  = 32'h00512223;

  typedef struct packed {
    logic [31:0] inst;
    logic        pre;
  } item_t;

  item_t exp_q[$];
  int    passed = 0;
  int    total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Every transfer must match the oldest expected micro-op.
  always @(negedge clk) begin
    item_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_pre", {31'b0, out_pre}, {31'b0, e.pre});
      end
    end
  end

  task automatic send(input logic [31:0] inst, input bit split, input logic [31:0] pre,
                      output int waits);
    item_t e;
    waits    = 0;
    in_valid = 1'b1;
    inst_in  = inst;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    if (in_ready) begin
      if (split) begin
        e.inst = pre;
        e.pre  = 1'b1;
        exp_q.push_back(e);
      end
      e.inst = inst;
      e.pre  = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inst_in  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_pre"}, {31'b0, out_pre}, 32'd0);
    chk({tag, "_out_inst"}, out_inst, 32'h00000000);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int w;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1 out_ready = 1'b1;

    // sb split with decode always ready
    send(SB_INST, 1'b1, SB_PRE, w);
    chk("sb_accept_wait", 32'(w), 32'd0);
    @(negedge clk);
    chk("sb_c1_in_ready", {31'b0, in_ready}, 32'd0);
    chk("sb_c1_out_pre", {31'b0, out_pre}, 32'd1);
    chk("sb_c1_out_inst", out_inst, SB_PRE);
    @(negedge clk);
    chk("sb_c2_out_inst", out_inst, SB_INST);
    chk("sb_c2_out_pre", {31'b0, out_pre}, 32'd0);
    chk("sb_c2_in_ready", {31'b0, in_ready}, 32'd1);
    drain();

    // Pass-through stream, back to back
    send(ADD_INST, 1'b0, '0, w);
    chk("add_wait", 32'(w), 32'd0);
    send(SW_INST, 1'b0, '0, w);
    chk("sw_wait", 32'(w), 32'd0);
    drain();

    // Instruction after a split waits only for the pre-load cycle
    send(SB_INST, 1'b1, SB_PRE, w);
    send(ADD_INST, 1'b0, '0, w);
    chk("add_after_sb_wait", 32'(w), 32'd1);
    drain();

    // Backpressure holds the pre-load stable
    out_ready = 1'b0;
    send(SB_INST, 1'b1, SB_PRE, w);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_inst", out_inst, SB_PRE);
      chk("bp_out_pre", {31'b0, out_pre}, 32'd1);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Flush while the pre-load is presented drops both halves
    out_ready = 1'b0;
    send(SB_INST, 1'b1, SB_PRE, w);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    chk("flush_presented", out_inst, SB_PRE);
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_no_emit", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a split
    out_ready = 1'b0;
    send(SB_INST, 1'b1, SB_PRE, w);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset("midpre_rst");
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_emit", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // sh handling depends on configuration
`ifdef STORE_SPLIT_HALF_EN
    send(SH_INST, 1'b1, SB_PRE, w);
    @(negedge clk);
    chk("sh_c1_out_pre", {31'b0, out_pre}, 32'd1);
`else
    send(SH_INST, 1'b0, '0, w);
    @(negedge clk);
    chk("sh_c1_out_pre", {31'b0, out_pre}, 32'd0);
`endif
    drain();

    // Mixed stream after config check
    send(SW_INST, 1'b0, '0, w);
    send(SB_INST, 1'b1, SB_PRE, w);
    send(ADD_INST, 1'b0, '0, w);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
